iface_rr_arbiter: RTL and testbench
===================================

Name: iface_rr_arbiter

Overview:
- Round-robin arbiter that shares one interface resource (1-bit valid strobe plus DATA_WIDTH-bit data bus) between N_REQ requesters.
- Each requester issues bursts. The arbiter grants one owner at a time and forwards the owner's data to the shared resource through a registered output.
- It bounds burst length with a hold counter so no requester can starve the others.
- Sits between the requesters and the shared interface instance, driving its input strobe and output data lanes.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 10, width of each requester data word and of the shared data bus.
- MAX_HOLD, 8, maximum beats per grant before forced release (1..255).

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  reset (synchronous, active-high).
- i_req  input  N_REQ  per-requester request; also acts as beat valid while granted.
- i_last  input  N_REQ  per-requester last-beat flag; sampled only with i_req of the owner.
- i_data  input  N_REQ x DATA_WIDTH  per-requester data word.
- o_grant  output  N_REQ  one-hot grant (all zero when idle).
- o_owner  output  $clog2(N_REQ)  index of the current owner; 0 when idle.
- o_valid  output  1  registered beat strobe to the shared resource.
- o_data  output  DATA_WIDTH  registered beat data to the shared resource.

Behaviour:
- One clock, i_clk. Reset is synchronous and active-high on i_rst.
- Reset values: state=IDLE, o_grant=0, o_owner=0, o_valid=0, o_data=0, rr pointer=0, hold count=0.
- Reset mid-burst discards the burst; outputs return to reset values on the next edge.
- States: IDLE, BUSY.
- Selection: first set bit of i_req scanning ptr, ptr+1, ..., ptr+N_REQ-1, with indices modulo N_REQ.
- IDLE:
  - If any i_req is set, register the selected index as owner and set o_grant one-hot. Go to BUSY with hold count 0.
  - Grant appears 1 cycle after the request. No beat is forwarded in the grant cycle.
- BUSY beat: a beat occurs in any cycle where i_req[owner]=1 and o_grant is set.
  - Next edge: o_valid=1, o_data=i_data[owner], hold count +1.
  - Non-beat cycles: o_valid=0 and o_data holds its last value.
- Release conditions, evaluated on the current cycle:
  - (a) beat with i_last[owner]=1;
  - (b) i_req[owner]=0;
  - (c) beat where hold count = MAX_HOLD-1.
- On release:
  - ptr <= owner+1, wrapping N_REQ-1 to 0.
  - If any other requester's i_req is set, select among those using the new ptr, excluding the releasing owner. Grant the next owner on the same edge (back-to-back, no idle bubble) and reset hold count to 0.
  - Otherwise: o_grant=0, o_owner=0, state=IDLE.
  - The releasing owner's final beat is still forwarded on that edge.
- Forced release (c): the requester keeps i_req high and is re-arbitrated normally. If it is the only requester, it is granted again immediately from IDLE on the next cycle.
- Requests from non-owners while BUSY are ignored until release. i_last of non-owners is ignored.
- Width rules:
  - hold count is $clog2(MAX_HOLD+1) bits and never exceeds MAX_HOLD-1 before wrap to 0.
  - ptr and o_owner are $clog2(N_REQ) bits. Increment uses explicit compare-to-N_REQ-1 wrap, valid for non-power-of-two N_REQ.
- o_grant is always one-hot or zero. A verification assertion checks this and that o_owner matches o_grant.

Decomposition:
- Package iface_arb_pkg holds:
  - state_t enum (IDLE, BUSY);
  - localparams OWNER_W and HOLD_W derived from parameters via functions;
  - a function next_index(idx, n) for the wrapping increment.
- Sub-module rr_pick (combinational rotating priority picker):
  - inputs: request vector, pointer, exclude mask;
  - outputs: found flag, index.
  - It is instantiated once and shared by the IDLE and release paths.
- The top holds the FSM, counters and output registers.

Test Plan:
- Single requester burst: i_req[2]=1 for 3 cycles after grant, i_last on beat 3, data 0x011/0x022/0x033 -> o_grant=0b0100 one cycle after request; o_valid pulses 3 cycles with those data; IDLE after; ptr=3.
- Round-robin fairness: all four hold i_req continuously and each asserts i_last on its 2nd beat -> owner sequence 0,1,2,3,0 with back-to-back grants and no idle cycle between owners.
- Forced release: only requester 1 holds i_req for 20 beats with no i_last, MAX_HOLD=8 -> release after beat 8 and beat 16; IDLE one cycle each; beats 1-8, 9-16, 17-20 forwarded; total 20 o_valid pulses.
- Abandon: owner 0 drops i_req after 1 beat while requester 3 requests -> release on the drop cycle; grant moves to 3 on the same edge; o_valid=0 in the drop cycle.
- Wrap and exclusion: ptr=3, requesters 3 and 0 request; owner 3 releases via i_last while still requesting -> next owner 0, never 3 twice.
- Reset mid-burst: assert i_rst for 1 cycle during beat 2 of owner 2 -> next edge all outputs 0 and state IDLE; a pending request is granted to the lowest index from ptr=0 one cycle after i_rst deasserts.

Source files
------------

// File: rtl/iface_rr_arbiter_pkg.sv
// Shared types and width helpers for the round-robin interface arbiter.
// Widths are derived per instance with the functions below.
package iface_arb_pkg;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  function automatic int owner_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int hold_w(input int max_hold);
    return (max_hold < 1) ? 1 : $clog2(max_hold + 1);
  endfunction

  // Wrapping increment; explicit compare so non-power-of-two counts work.
  function automatic int next_index(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_MAX_HOLD = 8;
  localparam int OWNER_W      = owner_w(DEF_N_REQ);
  localparam int HOLD_W       = hold_w(DEF_MAX_HOLD);

endpackage

// File: rtl/iface_rr_arbiter_if.sv
// Requester-side bundle plus the shared resource strobe/data lanes.
// slave is the arbiter's view; master is the requester/consumer side.
interface iface_rr_arbiter_if #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 10
);
  localparam int OW = (N_REQ < 2) ? 1 : $clog2(N_REQ);

  logic [N_REQ-1:0]                 i_req;
  logic [N_REQ-1:0]                 i_last;
  logic [N_REQ-1:0][DATA_WIDTH-1:0] i_data;
  logic [N_REQ-1:0]                 o_grant;
  logic [OW-1:0]                    o_owner;
  logic                             o_valid;
  logic [DATA_WIDTH-1:0]            o_data;

  modport slave (
    input  i_req, i_last, i_data,
    output o_grant, o_owner, o_valid, o_data
  );

  modport master (
    output i_req, i_last, i_data,
    input  o_grant, o_owner, o_valid, o_data
  );
endinterface

// File: rtl/iface_rr_arbiter_rr_pick.sv
// Rotating-priority picker: first set, non-excluded request at or after ptr.
// Purely combinational; one instance serves both IDLE and release paths.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic [N-1:0] excl,
  output logic         found,
  output logic [W-1:0] idx
);
  logic [N-1:0] cand;
  int           c;
  logic [W-1:0] ci;

  assign cand = req & ~excl;

  // Scan from farthest offset down so the nearest candidate wins last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    c     = 0;
    ci    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      ci = W'(c);
      if (cand[ci]) begin
        found = 1'b1;
        idx   = ci;
      end
    end
  end
endmodule

// File: rtl/iface_rr_arbiter.sv
// Round-robin burst arbiter sharing one registered valid/data lane among
// N_REQ requesters, with a hold counter bounding each grant.
module iface_rr_arbiter
  import iface_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 10,
  parameter int MAX_HOLD   = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  iface_rr_arbiter_if.slave   bus
);
  localparam int OWN_W = owner_w(N_REQ);
  localparam int HLD_W = hold_w(MAX_HOLD);
  localparam logic [HLD_W-1:0] HOLD_LAST = HLD_W'(MAX_HOLD - 1);

  state_t                  state_q, state_d;
  logic [OWN_W-1:0]        ptr_q, ptr_d;
  logic [OWN_W-1:0]        owner_q, owner_d;
  logic [N_REQ-1:0]        grant_q, grant_d;
  logic [HLD_W-1:0]        hold_q, hold_d;
  logic                    valid_q, valid_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;

  logic [OWN_W-1:0]        owner_inc;
  logic [OWN_W-1:0]        pick_ptr;
  logic [N_REQ-1:0]        pick_excl;
  logic                    pick_found;
  logic [OWN_W-1:0]        pick_idx;
  logic                    beat;
  logic                    rel;

  assign owner_inc = OWN_W'(next_index(int'(owner_q), N_REQ));

  // While busy the picker only matters on release, so it always looks
  // from the post-release pointer and skips the current owner.
  assign pick_ptr  = (state_q == BUSY) ? owner_inc : ptr_q;
  assign pick_excl = (state_q == BUSY) ? (N_REQ'(1) << owner_q) : '0;

  rr_pick #(.N(N_REQ), .W(OWN_W)) u_pick (
    .req   (bus.i_req),
    .ptr   (pick_ptr),
    .excl  (pick_excl),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    grant_d = grant_q;
    hold_d  = hold_q;
    valid_d = 1'b0;
    data_d  = data_q;
    beat    = 1'b0;
    rel     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = BUSY;
          owner_d = pick_idx;
          grant_d = N_REQ'(1) << pick_idx;
          hold_d  = '0;
        end
      end
      BUSY: begin
        beat = bus.i_req[owner_q];
        rel  = !beat || bus.i_last[owner_q] || (hold_q == HOLD_LAST);
        if (beat) begin
          valid_d = 1'b1;
          data_d  = bus.i_data[owner_q];
          hold_d  = HLD_W'(hold_q + 1'b1);
        end
        if (rel) begin
          ptr_d  = owner_inc;
          hold_d = '0;
          if (pick_found) begin
            owner_d = pick_idx;
            grant_d = N_REQ'(1) << pick_idx;
          end else begin
            state_d = IDLE;
            owner_d = '0;
            grant_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      grant_q <= '0;
      hold_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign bus.o_grant = grant_q;
  assign bus.o_owner = owner_q;
  assign bus.o_valid = valid_q;
  assign bus.o_data  = data_q;

endmodule

// File: tb/tb_iface_rr_arbiter.sv
// Bench for iface_rr_arbiter: fixed vector table, directed corner sequences
// and a random phase checked against a transaction-level reference model.
module tb_iface_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 10;
  localparam int MH = 8;

  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  iface_rr_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW)) bus ();

  iface_rr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .MAX_HOLD(MH)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  int nvec = 0;
  int nerr = 0;

  // Reference model: owner as int (-1 idle), beats taken in current grant.
  int         m_own = -1;
  int         m_ptr = 0;
  int         m_beats = 0;
  logic       e_valid = 1'b0;
  logic [9:0] e_data = '0;

  function automatic int pick(input logic [N-1:0] r, input int p, input int ex);
    for (int i = 0; i < N; i++) begin
      int j;
      j = (p + i) % N;
      if (r[j] && j != ex) return j;
    end
    return -1;
  endfunction

  task automatic model_step();
    int o;
    bit rel;
    if (i_rst) begin
      m_own = -1; m_ptr = 0; m_beats = 0; e_valid = 0; e_data = '0;
      return;
    end
    e_valid = 0;
    if (m_own < 0) begin
      m_own = pick(bus.i_req, m_ptr, -1);
      m_beats = 0;
    end else begin
      o = m_own;
      rel = 0;
      if (bus.i_req[o]) begin
        e_valid = 1;
        e_data  = bus.i_data[o];
        m_beats++;
        if (bus.i_last[o] || m_beats >= MH) rel = 1;
      end else begin
        rel = 1;
      end
      if (rel) begin
        m_ptr = (o + 1) % N;
        m_own = pick(bus.i_req, m_ptr, o);
        m_beats = 0;
      end
    end
  endtask

  task automatic drive(input logic rst, input logic [3:0] req, input logic [3:0] last,
                       input logic [7:0] d);
    i_rst      = rst;
    bus.i_req  = req;
    bus.i_last = last;
    for (int k = 0; k < N; k++) bus.i_data[k] = {2'(k), d};
  endtask

  task automatic tick();
    model_step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_eq(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %0s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model(input string name);
    logic [3:0] eg;
    logic [1:0] eo;
    bit         bad;
    eg = (m_own < 0) ? 4'b0 : 4'(1 << m_own);
    eo = (m_own < 0) ? 2'd0 : 2'(m_own);
    bad = (bus.o_grant !== eg) || (bus.o_owner !== eo) ||
          (bus.o_valid !== e_valid) || (bus.o_data !== e_data);
    if (!$onehot0(bus.o_grant)) bad = 1;
    if (bus.o_grant != 0 && !bus.o_grant[bus.o_owner]) bad = 1;
    if (bus.o_grant == 0 && bus.o_owner != 0) bad = 1;
    nvec++;
    if (bad) begin
      nerr++;
      $display("FAIL %0s: grant=%b owner=%0d valid=%b data=%h, expected grant=%b owner=%0d valid=%b data=%h",
               name, bus.o_grant, bus.o_owner, bus.o_valid, bus.o_data, eg, eo, e_valid, e_data);
    end
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] last;
    logic [7:0] d;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       valid;
    logic [9:0] data;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int seq[$];
    int idle, beats, cyc;
    tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 8'h00, 4'b0000, 2'd0, 1'b0, 10'h000};
    tbl[1]  = '{1'b0, 4'b0100, 4'b0000, 8'h00, 4'b0100, 2'd2, 1'b0, 10'h000};
    tbl[2]  = '{1'b0, 4'b0100, 4'b0000, 8'h11, 4'b0100, 2'd2, 1'b1, 10'h211};
    tbl[3]  = '{1'b0, 4'b0100, 4'b0000, 8'h22, 4'b0100, 2'd2, 1'b1, 10'h222};
    tbl[4]  = '{1'b0, 4'b0100, 4'b0100, 8'h33, 4'b0000, 2'd0, 1'b1, 10'h233};
    tbl[5]  = '{1'b0, 4'b0000, 4'b0000, 8'h00, 4'b0000, 2'd0, 1'b0, 10'h233};
    tbl[6]  = '{1'b0, 4'b1111, 4'b0000, 8'h00, 4'b1000, 2'd3, 1'b0, 10'h233};
    tbl[7]  = '{1'b0, 4'b1111, 4'b1000, 8'h44, 4'b0001, 2'd0, 1'b1, 10'h344};
    tbl[8]  = '{1'b0, 4'b0000, 4'b0000, 8'h55, 4'b0000, 2'd0, 1'b0, 10'h344};
    tbl[9]  = '{1'b0, 4'b0000, 4'b0000, 8'h00, 4'b0000, 2'd0, 1'b0, 10'h344};
    tbl[10] = '{1'b0, 4'b0011, 4'b0000, 8'h00, 4'b0010, 2'd1, 1'b0, 10'h344};
    tbl[11] = '{1'b0, 4'b0011, 4'b0010, 8'h66, 4'b0001, 2'd0, 1'b1, 10'h166};
    tbl[12] = '{1'b1, 4'b0011, 4'b0000, 8'h00, 4'b0000, 2'd0, 1'b0, 10'h000};

    drive(1'b1, 4'b0, 4'b0, 8'h0);
    tick();
    tick();

    // Table phase: single burst, ptr carry-over, abandon, exclusion, reset.
    for (int v = 0; v < 13; v++) begin
      drive(tbl[v].rst, tbl[v].req, tbl[v].last, tbl[v].d);
      tick();
      nvec++;
      if (bus.o_grant !== tbl[v].grant || bus.o_owner !== tbl[v].owner ||
          bus.o_valid !== tbl[v].valid || bus.o_data !== tbl[v].data) begin
        nerr++;
        $display("FAIL vec%0d: grant=%b owner=%0d valid=%b data=%h, expected grant=%b owner=%0d valid=%b data=%h",
                 v, bus.o_grant, bus.o_owner, bus.o_valid, bus.o_data,
                 tbl[v].grant, tbl[v].owner, tbl[v].valid, tbl[v].data);
      end
    end

    // Fairness: everyone requesting, last on each owner's second beat.
    drive(1'b1, 4'b0, 4'b0, 8'h0); tick();
    idle = 0; cyc = 0;
    while (seq.size() < 5 && cyc < 40) begin
      drive(1'b0, 4'b1111, (m_own >= 0 && m_beats == 1) ? 4'(1 << m_own) : 4'b0, 8'(cyc));
      tick();
      check_model("fair");
      if (bus.o_grant != 0 && (seq.size() == 0 || seq[$] != int'(bus.o_owner)))
        seq.push_back(int'(bus.o_owner));
      else if (bus.o_grant == 0 && seq.size() != 0)
        idle++;
      cyc++;
    end
    check_eq("fair_count", seq.size(), 5);
    if (seq.size() == 5) begin
      check_eq("fair_o0", seq[0], 0); check_eq("fair_o1", seq[1], 1);
      check_eq("fair_o2", seq[2], 2); check_eq("fair_o3", seq[3], 3);
      check_eq("fair_o4", seq[4], 0);
    end
    check_eq("fair_idle", idle, 0);

    // Forced release: lone requester 1 streams 20 beats without last.
    drive(1'b1, 4'b0, 4'b0, 8'h0); tick();
    beats = 0; idle = 0; cyc = 0;
    while (beats < 20 && cyc < 100) begin
      drive(1'b0, 4'b0010, 4'b0, 8'(beats + 1));
      tick();
      check_model("force");
      if (bus.o_valid) begin
        beats++;
        check_eq("force_data", int'(bus.o_data), int'({2'd1, 8'(beats)}));
      end
      if (bus.o_grant == 0 && cyc > 0) idle++;
      cyc++;
    end
    check_eq("force_beats", beats, 20);
    check_eq("force_idle", idle, 2);
    drive(1'b0, 4'b0, 4'b0, 8'h0); tick(); check_model("force_end");

    // Abandon: owner 0 drops after one beat while 3 waits.
    drive(1'b1, 4'b0, 4'b0, 8'h0); tick();
    drive(1'b0, 4'b0001, 4'b0, 8'h01); tick(); check_model("abn_grant");
    drive(1'b0, 4'b1001, 4'b0, 8'h02); tick(); check_model("abn_beat");
    drive(1'b0, 4'b1000, 4'b0, 8'h03); tick(); check_model("abn_drop");
    check_eq("abn_grant3", int'(bus.o_grant), 8);
    check_eq("abn_novalid", int'(bus.o_valid), 0);

    // Wrap and exclusion: ptr reaches 3, owner 3 releases, 0 must follow.
    drive(1'b1, 4'b0, 4'b0, 8'h0); tick();
    drive(1'b0, 4'b0100, 4'b0000, 8'h10); tick(); check_model("wrap_g2");
    drive(1'b0, 4'b0100, 4'b0100, 8'h11); tick(); check_model("wrap_r2");
    drive(1'b0, 4'b1001, 4'b0000, 8'h12); tick(); check_model("wrap_g3");
    check_eq("wrap_owner3", int'(bus.o_owner), 3);
    drive(1'b0, 4'b1001, 4'b1000, 8'h13); tick(); check_model("wrap_r3");
    check_eq("wrap_owner0", int'(bus.o_owner), 0);
    drive(1'b0, 4'b1001, 4'b0001, 8'h14); tick(); check_model("wrap_r0");

    // Reset during beat 2 of owner 2, then lowest index wins from ptr 0.
    drive(1'b1, 4'b0, 4'b0, 8'h0); tick();
    drive(1'b0, 4'b1000, 4'b0, 8'h00); tick();
    drive(1'b0, 4'b0000, 4'b0, 8'h00); tick();
    drive(1'b0, 4'b0000, 4'b0, 8'h00); tick();
    drive(1'b0, 4'b0100, 4'b0, 8'h20); tick(); check_model("rst_g2");
    drive(1'b0, 4'b0100, 4'b0, 8'h21); tick(); check_model("rst_b1");
    drive(1'b1, 4'b0110, 4'b0, 8'h22); tick(); check_model("rst_hit");
    check_eq("rst_grant", int'(bus.o_grant), 0);
    check_eq("rst_data", int'(bus.o_data), 0);
    drive(1'b0, 4'b0110, 4'b0, 8'h23); tick(); check_model("rst_regrant");
    check_eq("rst_owner1", int'(bus.o_owner), 1);

    // Random phase against the model.
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom_range(0, 99) == 0), 4'($urandom), 4'($urandom_range(0, 15) & $urandom),
            8'($urandom));
      tick();
      check_model("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
